// File: rtl/instr_sequencer.sv
// Hardwired control sequencer for the single-bus CPU datapath.
// Steps fetch (T0-T2) and register-register ALU execute (T3-T5).
module instr_sequencer #(
  parameter int OPW = 5,
  parameter int RSW = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                Yin,
  output logic                IRin,
  output logic                Read,
  output logic [2**RSW-1:0]   reg_out,
  output logic [2**RSW-1:0]   reg_in,
  output logic [3:0]          alu_op,
  output logic                run
);

  localparam int NREG = 2 ** RSW;
  localparam int RA_HI = 31 - OPW;
  localparam int RB_HI = RA_HI - RSW;
  localparam int RC_HI = RB_HI - RSW;
  localparam int LOW_HI = RC_HI - RSW;

  typedef enum logic [2:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    HALT
  } state_t;

  state_t state;

  logic [OPW-1:0]  opc;
  logic [RSW-1:0]  ra;
  logic [RSW-1:0]  rb;
  logic [RSW-1:0]  rc;
  logic            is_alu;
  logic            is_halt;
  logic [3:0]      code;
  logic [NREG-1:0] sel_ra;
  logic [NREG-1:0] sel_rb;
  logic [NREG-1:0] sel_rc;
  logic            unused_ir;

  assign opc = ir[31 -: OPW];
  assign ra  = ir[RA_HI -: RSW];
  assign rb  = ir[RB_HI -: RSW];
  assign rc  = ir[RC_HI -: RSW];

  // Immediate/unused low IR bits carry no control meaning here.
  assign unused_ir = ^ir[LOW_HI:0];

  assign is_alu  = (opc >= OPW'(3)) && (opc <= OPW'(11));
  assign is_halt = (opc == OPW'(27));
  assign code    = 4'(opc - OPW'(2));

  assign sel_ra = NREG'(1) << ra;
  assign sel_rb = NREG'(1) << rb;
  assign sel_rc = NREG'(1) << rc;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: state <= T0;
        T0:   state <= T1;
        T1:   if (mem_ready) state <= T2;
        T2:   state <= T3;
        T3: begin
          if (is_alu)       state <= T4;
          else if (is_halt) state <= HALT;
          else              state <= T0;
        end
        T4:   state <= T5;
        T5:   state <= T0;
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async clear drops them at once.
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    Yin     = 1'b0;
    IRin    = 1'b0;
    Read    = 1'b0;
    reg_out = '0;
    reg_in  = '0;
    alu_op  = '0;
    run     = 1'b0;
    unique case (state)
      T0: begin
        run   = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        run     = 1'b1;
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        run = 1'b1;
        if (is_alu) begin
          reg_out = sel_rb;
          Yin     = 1'b1;
        end
      end
      T4: begin
        run     = 1'b1;
        reg_out = sel_rc;
        Zin     = 1'b1;
        alu_op  = code;
      end
      T5: begin
        run     = 1'b1;
        Zlowout = 1'b1;
        reg_in  = sel_ra;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: per-cycle expected
// control vectors are queued with stimulus and checked at negedge.
module tb_instr_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PCout, Zlowout, MDRout, MARin, IncPC, Zin;
  logic        PCin, MDRin, Yin, IRin, Read, run;
  logic [15:0] reg_out;
  logic [15:0] reg_in;
  logic [3:0]  alu_op;
  logic [47:0] obs;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        mr;
    logic [47:0] e;
    string       n;
  } stim_t;

  stim_t plan[$];
  stim_t sb[$];

  // strobe order: PCout Zlowout MDRout MARin IncPC Zin PCin MDRin Yin IRin Read
  localparam logic [10:0] S_T0 = 11'b10011100000;
  localparam logic [10:0] S_T1 = 11'b01000011001;
  localparam logic [10:0] S_T2 = 11'b00100000010;
  localparam logic [10:0] S_T3 = 11'b00000000100;
  localparam logic [10:0] S_T4 = 11'b00000100000;
  localparam logic [10:0] S_T5 = 11'b01000000000;

  instr_sequencer #(.OPW(5), .RSW(4)) dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
    .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .Yin(Yin), .IRin(IRin), .Read(Read),
    .reg_out(reg_out), .reg_in(reg_in), .alu_op(alu_op),
    .run(run)
  );

  assign obs = {run, PCout, Zlowout, MDRout, MARin, IncPC, Zin,
                PCin, MDRin, Yin, IRin, Read, reg_out, reg_in, alu_op};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [47:0] mk(logic [10:0] s, logic [15:0] ro,
                                     logic [15:0] ri, logic [3:0] op,
                                     logic rn);
    return {rn, s, ro, ri, op};
  endfunction

  function automatic logic [15:0] oh(logic [3:0] i);
    return 16'(1) << i;
  endfunction

  function automatic logic [31:0] mkir(logic [4:0] op, logic [3:0] a,
                                       logic [3:0] b, logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  task automatic add(logic mr, logic [47:0] e, string n);
    stim_t s;
    s.mr = mr;
    s.e = e;
    s.n = n;
    plan.push_back(s);
  endtask

  task automatic add_fetch(int stalls);
    add(stalls == 0, mk(S_T1, 0, 0, 0, 1), "t1");
    for (int i = 0; i < stalls; i++)
      add(1'b0, mk(S_T1, 0, 0, 0, 1), "t1_stall");
    add(1'b1, mk(S_T2, 0, 0, 0, 1), "t2");
  endtask

  task automatic add_exec(logic [3:0] a, logic [3:0] b, logic [3:0] c,
                          logic [3:0] code, logic mr);
    add(mr, mk(S_T3, oh(b), 0, 0, 1), "t3");
    add(mr, mk(S_T4, oh(c), 0, code, 1), "t4");
    add(mr, mk(S_T5, 0, oh(a), 0, 1), "t5");
    add(mr, mk(S_T0, 0, 0, 0, 1), "t0");
  endtask

  // No two bus drivers, one-hot register selects, whenever not in reset.
  always @(negedge clock) begin
    if (clear) begin
      total++;
      if ($countones({PCout, Zlowout, MDRout, |reg_out}) > 1 ||
          $countones(reg_out) > 1 || $countones(reg_in) > 1) begin
        bad++;
        $display("FAIL bus_conflict: got=%h want=at_most_one_driver",
                 obs);
      end
    end
  end

  task automatic test_reset();
    stim_t g;
    stim_t c;
    clear = 1'b0;
    mem_ready = 1'b1;
    ir = 32'd0;
    add(1'b1, 48'd0, "in_reset");
    add(1'b1, 48'd0, "in_reset");
    while (plan.size() > 0) begin
      c = plan.pop_front();
      mem_ready = c.mr;
      sb.push_back(c);
      @(posedge clock); @(negedge clock);
      g = sb.pop_front();
      total++;
      if (obs !== g.e) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", g.n, obs, g.e);
      end
    end
    clear = 1'b1;
    #1;
    total++;
    if (obs !== 48'd0) begin
      bad++;
      $display("FAIL idle: got=%h want=%h", obs, 48'd0);
    end
    add(1'b1, mk(S_T0, 0, 0, 0, 1), "first_t0");
    while (plan.size() > 0) begin
      c = plan.pop_front();
      mem_ready = c.mr;
      sb.push_back(c);
      @(posedge clock); @(negedge clock);
      g = sb.pop_front();
      total++;
      if (obs !== g.e) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", g.n, obs, g.e);
      end
    end
  endtask

  task automatic test_or();
    stim_t g;
    stim_t c;
    ir = 32'h3091_8000;
    add_fetch(0);
    add_exec(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      mem_ready = c.mr;
      sb.push_back(c);
      @(posedge clock); @(negedge clock);
      g = sb.pop_front();
      total++;
      if (obs !== g.e) begin
        bad++;
        $display("FAIL or_%s: got=%h want=%h", g.n, obs, g.e);
      end
    end
  endtask

  task automatic test_stall();
    stim_t g;
    stim_t c;
    ir = mkir(5'b00011, 4'd4, 4'd9, 4'd15);
    add_fetch(3);
    add_exec(4'd4, 4'd9, 4'd15, 4'd1, 1'b0);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      mem_ready = c.mr;
      sb.push_back(c);
      @(posedge clock); @(negedge clock);
      g = sb.pop_front();
      total++;
      if (obs !== g.e) begin
        bad++;
        $display("FAIL stall_%s: got=%h want=%h", g.n, obs, g.e);
      end
    end
  endtask

  task automatic test_opcode_sweep();
    stim_t g;
    stim_t c;
    for (int op = 3; op <= 11; op++) begin
      ir = mkir(5'(op), 4'd5, 4'd6, 4'd7);
      add_fetch(op % 2);
      add_exec(4'd5, 4'd6, 4'd7, 4'(op - 2), 1'($urandom_range(0, 1)));
      while (plan.size() > 0) begin
        c = plan.pop_front();
        mem_ready = c.mr;
        sb.push_back(c);
        @(posedge clock); @(negedge clock);
        g = sb.pop_front();
        total++;
        if (obs !== g.e) begin
          bad++;
          $display("FAIL sweep_op%0d_%s: got=%h want=%h",
                   op, g.n, obs, g.e);
        end
      end
    end
  endtask

  task automatic test_same_reg();
    stim_t g;
    stim_t c;
    ir = mkir(5'b00110, 4'd1, 4'd1, 4'd1);
    add_fetch(0);
    add_exec(4'd1, 4'd1, 4'd1, 4'd4, 1'b1);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      mem_ready = c.mr;
      sb.push_back(c);
      @(posedge clock); @(negedge clock);
      g = sb.pop_front();
      total++;
      if (obs !== g.e) begin
        bad++;
        $display("FAIL same_reg_%s: got=%h want=%h", g.n, obs, g.e);
      end
    end
  endtask

  task automatic test_nop_halt();
    stim_t g;
    stim_t c;
    ir = mkir(5'b11010, 4'd2, 4'd3, 4'd4);
    add_fetch(0);
    add(1'b1, mk(11'd0, 0, 0, 0, 1), "nop_t3");
    add(1'b1, mk(S_T0, 0, 0, 0, 1), "nop_t0");
    while (plan.size() > 0) begin
      c = plan.pop_front();
      mem_ready = c.mr;
      sb.push_back(c);
      @(posedge clock); @(negedge clock);
      g = sb.pop_front();
      total++;
      if (obs !== g.e) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", g.n, obs, g.e);
      end
    end
    ir = mkir(5'b11011, 4'd2, 4'd3, 4'd4);
    add_fetch(0);
    add(1'b1, mk(11'd0, 0, 0, 0, 1), "halt_t3");
    for (int i = 0; i < 10; i++)
      add(1'($urandom_range(0, 1)), 48'd0, "halted");
    while (plan.size() > 0) begin
      c = plan.pop_front();
      mem_ready = c.mr;
      sb.push_back(c);
      @(posedge clock); @(negedge clock);
      g = sb.pop_front();
      total++;
      if (obs !== g.e) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", g.n, obs, g.e);
      end
    end
    clear = 1'b0;
    @(posedge clock); @(negedge clock);
    clear = 1'b1;
    ir = mkir(5'b00101, 4'd3, 4'd0, 4'd8);
    add(1'b1, mk(S_T0, 0, 0, 0, 1), "restart_t0");
    add_fetch(0);
    add_exec(4'd3, 4'd0, 4'd8, 4'd3, 1'b1);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      mem_ready = c.mr;
      sb.push_back(c);
      @(posedge clock); @(negedge clock);
      g = sb.pop_front();
      total++;
      if (obs !== g.e) begin
        bad++;
        $display("FAIL restart_%s: got=%h want=%h", g.n, obs, g.e);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t g;
    stim_t c;
    ir = mkir(5'b00011, 4'd1, 4'd2, 4'd3);
    add_fetch(1);
    add(1'b1, mk(S_T3, oh(4'd2), 0, 0, 1), "t3");
    add(1'b1, mk(S_T4, oh(4'd3), 0, 4'd1, 1), "t4");
    while (plan.size() > 0) begin
      c = plan.pop_front();
      mem_ready = c.mr;
      sb.push_back(c);
      @(posedge clock); @(negedge clock);
      g = sb.pop_front();
      total++;
      if (obs !== g.e) begin
        bad++;
        $display("FAIL async_%s: got=%h want=%h", g.n, obs, g.e);
      end
    end
    #1 clear = 1'b0;
    #1;
    total++;
    if (obs !== 48'd0) begin
      bad++;
      $display("FAIL async_drop: got=%h want=%h", obs, 48'd0);
    end
    @(negedge clock);
    clear = 1'b1;
    add(1'b1, mk(S_T0, 0, 0, 0, 1), "t0");
    add_fetch(0);
    add_exec(4'd1, 4'd2, 4'd3, 4'd1, 1'b1);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      mem_ready = c.mr;
      sb.push_back(c);
      @(posedge clock); @(negedge clock);
      g = sb.pop_front();
      total++;
      if (obs !== g.e) begin
        bad++;
        $display("FAIL async_restart_%s: got=%h want=%h",
                 g.n, obs, g.e);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_or();
    test_stall();
    test_opcode_sweep();
    test_same_reg();
    test_nop_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
